// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-addressed data RAM with fixed access latency, stall and misalignment flagging
module data_mem_ctrl #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        Stall,
  output logic        AddrErr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [AW-1:0] idx, idx_l;
  logic [31:0] wd_l;
  logic st_l, req, idle, go, done;
  logic [31:0] mem [DEPTH];
  logic unused_hi;
  assign unused_hi = ^A[31:AW+2];
  assign idx = A[AW+1:2];
  // Reset masks the request so nothing is flagged or stalled while it is held
  assign req = Reset && (MemRead || MemWrite);
  assign idle = state == S_IDLE;
  assign AddrErr = idle && req && A[1:0] != 2'b00;
  assign go = idle && req && A[1:0] == 2'b00;
  assign done = Reset && state == S_WAIT && cnt == 4'd0;
  assign Stall = WAIT_CYCLES != 0 && (go || (state == S_WAIT && cnt != 4'd0));
  assign RD = WAIT_CYCLES == 0 ? (go && !MemWrite ? mem[idx] : '0)
                               : (done && !st_l ? mem[idx_l] : '0);
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state <= S_IDLE;
      cnt <= '0;
      idx_l <= '0;
      wd_l <= '0;
      st_l <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (go && WAIT_CYCLES != 0) begin
        state <= S_WAIT;
        cnt <= WC - 4'd1;
        idx_l <= idx;
        wd_l <= WD;
        st_l <= MemWrite;
      end else if (state == S_WAIT) begin
        state <= cnt == 4'd0 ? S_IDLE : S_WAIT;
        cnt <= cnt - 4'd1;
      end
      if (WAIT_CYCLES == 0 && go && MemWrite) mem[idx] <= WD;
      if (done && st_l) mem[idx_l] <= wd_l;
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed scoreboard bench for the two-wait-state and zero-wait variants
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic Reset, MemRead, MemWrite, MemRead0, MemWrite0;
  logic [31:0] A, WD, A0, WD0, RD, RD0;
  logic Stall, AddrErr, Stall0, AddrErr0;
  int tests = 0, fails = 0;
  logic [31:0] q [$];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .CLK(clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .A(A), .WD(WD), .RD(RD), .Stall(Stall), .AddrErr(AddrErr));

  data_mem_ctrl #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .Reset(Reset), .MemRead(MemRead0), .MemWrite(MemWrite0),
    .A(A0), .WD(WD0), .RD(RD0), .Stall(Stall0), .AddrErr(AddrErr0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full access on the WAIT_CYCLES=2 instance; A/WD are scrambled mid-access
  task automatic mem_op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd);
    MemRead = r; MemWrite = w; A = a; WD = d;
    q.push_back(exp_rd);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_busy", 32'(Stall), 32'd1);
      chk("rd_busy", RD, 32'd0);
      chk("adderr_busy", 32'(AddrErr), 32'd0);
      tick();
      A = $urandom; WD = $urandom;
    end
    @(negedge clk);
    chk("stall_done", 32'(Stall), 32'd0);
    chk("adderr_done", 32'(AddrErr), 32'd0);
    chk("rd_done", RD, q.pop_front());
    tick();
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    MemRead = 0; MemWrite = 1; A = 32'h8; WD = 32'hFFFF_FFFF; Reset = 0;
    MemRead0 = 0; MemWrite0 = 0; A0 = 0; WD0 = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_stall", 32'(Stall), 32'd0);
      chk("rst_rd", RD, 32'd0);
      chk("rst_adderr", 32'(AddrErr), 32'd0);
      tick();
    end
    Reset = 1; MemWrite = 0;
    @(negedge clk);
    chk("post_rst_stall", 32'(Stall), 32'd0);
    chk("post_rst_rd", RD, 32'd0);
    tick();
    mem_op(1, 0, 32'h8, 0, 32'h0);
    mem_op(1, 0, 32'hFC, 0, 32'h0);
    mem_op(0, 1, 32'h8, 32'hDEAD_BEEF, 32'h0);
    mem_op(1, 0, 32'h8, 0, 32'hDEAD_BEEF);
    MemRead = 1; A = 32'h6;
    @(negedge clk);
    chk("mis_adderr", 32'(AddrErr), 32'd1);
    chk("mis_stall", 32'(Stall), 32'd0);
    chk("mis_rd", RD, 32'd0);
    tick();
    MemRead = 0; MemWrite = 1; A = 32'hA; WD = 32'h5555_5555;
    @(negedge clk);
    chk("mis_st_adderr", 32'(AddrErr), 32'd1);
    chk("mis_st_stall", 32'(Stall), 32'd0);
    tick();
    MemWrite = 0;
    @(negedge clk);
    chk("mis_pulse_end", 32'(AddrErr), 32'd0);
    tick();
    mem_op(1, 0, 32'h8, 0, 32'hDEAD_BEEF);
    mem_op(0, 1, 32'h100, 32'h1234, 32'h0);
    mem_op(1, 0, 32'h0, 0, 32'h0000_1234);
    mem_op(0, 1, 32'h4, 32'hA5A5_A5A5, 32'h0);
    mem_op(1, 0, 32'h4, 0, 32'hA5A5_A5A5);
    mem_op(1, 0, 32'h8, 0, 32'hDEAD_BEEF);
    mem_op(1, 0, 32'h0, 0, 32'h0000_1234);
    mem_op(1, 1, 32'h14, 32'h99, 32'h0);
    mem_op(1, 0, 32'h14, 0, 32'h99);
    MemWrite = 1; A = 32'h10; WD = 32'h77;
    @(negedge clk);
    chk("mid_rst_req", 32'(Stall), 32'd1);
    tick();
    MemWrite = 0; Reset = 0;
    tick();
    Reset = 1;
    @(negedge clk);
    chk("mid_rst_stall", 32'(Stall), 32'd0);
    chk("mid_rst_rd", RD, 32'd0);
    tick();
    mem_op(1, 0, 32'h10, 0, 32'h0);
    mem_op(1, 0, 32'h8, 0, 32'h0);
    MemWrite0 = 1; A0 = 32'hC; WD0 = 32'd7;
    q.push_back(32'd0);
    @(negedge clk);
    chk("w0_st_stall", 32'(Stall0), 32'd0);
    chk("w0_st_rd", RD0, q.pop_front());
    tick();
    MemWrite0 = 0; MemRead0 = 1;
    q.push_back(32'd7);
    @(negedge clk);
    chk("w0_ld_stall", 32'(Stall0), 32'd0);
    chk("w0_ld_rd", RD0, q.pop_front());
    tick();
    A0 = 32'hD;
    @(negedge clk);
    chk("w0_mis_adderr", 32'(AddrErr0), 32'd1);
    chk("w0_mis_rd", RD0, 32'd0);
    tick();
    MemRead0 = 0;
    @(negedge clk);
    chk("w0_idle_rd", RD0, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
